// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: datapath width, divider step count
// and the divider state encoding.
package arith_pkg;

  localparam int ARITH_WIDTH = 20;
  localparam int DIV_STEPS   = ARITH_WIDTH;
  localparam int DIV_CNT_W   = $clog2(DIV_STEPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div20_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep or restore.
module div20_step
  import arith_pkg::*;
(
  input  logic [ARITH_WIDTH:0]   r,
  input  logic [ARITH_WIDTH-1:0] qw,
  input  logic [ARITH_WIDTH-1:0] dsr,
  output logic [ARITH_WIDTH:0]   r_next,
  output logic [ARITH_WIDTH-1:0] qw_next
);

  logic [ARITH_WIDTH:0] t;
  logic [ARITH_WIDTH:0] d;
  logic                 unused_r_msb;

  // The partial remainder stays below the divisor, so its top bit is always 0.
  assign unused_r_msb = r[ARITH_WIDTH];

  assign t       = {r[ARITH_WIDTH-1:0], qw[ARITH_WIDTH-1]};
  assign d       = t - {1'b0, dsr};
  assign r_next  = d[ARITH_WIDTH] ? t : d;
  assign qw_next = {qw[ARITH_WIDTH-2:0], ~d[ARITH_WIDTH]};

endmodule

// File: rtl/div20_seq.sv
// Sequential 20-bit unsigned restoring divider: one step per clock, 20 steps,
// registered quotient/remainder/div_by_zero updated only on completion.
module div20_seq
  import arith_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ARITH_WIDTH-1:0] dividend,
  input  logic [ARITH_WIDTH-1:0] divisor,
  output logic                   busy,
  output logic                   done,
  output logic [ARITH_WIDTH-1:0] quotient,
  output logic [ARITH_WIDTH-1:0] remainder,
  output logic                   div_by_zero
);

  // Handshake: start is a request that is accepted on a rising edge only when
  // busy=0 and no divide-by-zero result is pending; dividend/divisor are
  // captured on that edge alone. done is a one-cycle pulse, results held after.

  div_state_t             state, state_next;
  logic                   dz_pend, dz_pend_next;
  logic [ARITH_WIDTH-1:0] qw, qw_next;
  logic [ARITH_WIDTH:0]   r, r_next;
  logic [ARITH_WIDTH-1:0] dsr, dsr_next;
  logic [DIV_CNT_W-1:0]   count, count_next;
  logic [ARITH_WIDTH-1:0] quotient_next, remainder_next;
  logic                   div_by_zero_next;

  logic [ARITH_WIDTH:0]   step_r;
  logic [ARITH_WIDTH-1:0] step_qw;

  div20_step u_step (
    .r       (r),
    .qw      (qw),
    .dsr     (dsr),
    .r_next  (step_r),
    .qw_next (step_qw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dz_pend     <= 1'b0;
      qw          <= '0;
      r           <= '0;
      dsr         <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_next;
      dz_pend     <= dz_pend_next;
      qw          <= qw_next;
      r           <= r_next;
      dsr         <= dsr_next;
      count       <= count_next;
      quotient    <= quotient_next;
      remainder   <= remainder_next;
      div_by_zero <= div_by_zero_next;
    end
  end

  always_comb begin
    state_next       = state;
    dz_pend_next     = 1'b0;
    qw_next          = qw;
    r_next           = r;
    dsr_next         = dsr;
    count_next       = count;
    quotient_next    = quotient;
    remainder_next   = remainder;
    div_by_zero_next = div_by_zero;

    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (dz_pend) begin
          // Zero divisor: skip RUN, report one cycle after acceptance.
          state_next       = DONE;
          quotient_next    = '1;
          remainder_next   = qw;
          div_by_zero_next = 1'b1;
        end else if (start) begin
          qw_next    = dividend;
          r_next     = '0;
          dsr_next   = divisor;
          count_next = '0;
          if (divisor == '0) begin
            dz_pend_next = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        qw_next    = step_qw;
        r_next     = step_r;
        count_next = count + DIV_CNT_W'(1);
        if (count == DIV_CNT_W'(DIV_STEPS - 1)) begin
          state_next       = DONE;
          quotient_next    = step_qw;
          remainder_next   = step_r[ARITH_WIDTH-1:0];
          div_by_zero_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: doc/div20_seq.md
# div20_seq

Sequential 20-bit unsigned restoring divider for the arithmetic library. It takes a dividend and divisor on a start pulse and performs one shift/subtract step per clock, 20 steps in all. It returns quotient and remainder with a one-cycle done pulse. It is the iterative inverse-operation companion to the combinational add/subtract units and feeds the same 20-bit datapath.

## Interface
- WIDTH, 20, operand/result width; all values unsigned.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- dividend  input  WIDTH  sampled on the accepting edge.
- divisor  input  WIDTH  sampled on the accepting edge.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse; results valid from this cycle.
- quotient  output  WIDTH  last completed quotient, held.
- remainder  output  WIDTH  last completed remainder, held.
- div_by_zero  output  1  flag for the last completed operation, held.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 → RUN. On entry: load working quotient qw=dividend, partial remainder r (WIDTH+1 bits)=0, dsr=divisor, step count=0.
- Zero divisor at accept: go to DONE directly, no RUN. Set quotient=all ones (0xFFFFF), remainder=dividend, div_by_zero=1.
- RUN step:
  - t={r[WIDTH-1:0], qw[WIDTH-1]}, qw shifted left.
  - d=t−{0,dsr}.
  - If d[WIDTH]=0: r=d, qw LSB=1. Else r=t, qw LSB=0.
  - count++.
- After the 20th step → DONE. Register quotient=qw, remainder=r[WIDTH-1:0], div_by_zero=0.
- DONE lasts one cycle (done=1). Then IDLE unless start=1, which is accepted from DONE, giving back-to-back operation.
- Output registers change only on completion. They hold the previous result throughout RUN.
- start while busy=1 is ignored, with no queueing. Operands are ignored except on the accepting edge.
- rst (any time, including mid-RUN):
  - state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counters cleared.
  - An in-flight operation is discarded and produces no done.

## Timing
- Accepting edge E0. busy=1 after E0 through E20.
- Steps occur at E1..E20. At E20 the state becomes DONE, results update, done=1 and busy=0.
- done falls after E21. Latency is 20 cycles from start to done.
- Divide-by-zero: done=1 after E1, a 1-cycle latency. busy is never asserted.
- Invariant: quotient×divisor+remainder=dividend and remainder<divisor, for divisor≠0.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Shared package arith_pkg:
  - ARITH_WIDTH=20.
  - State enum div_state_t {IDLE, RUN, DONE}.
  - DIV_STEPS=ARITH_WIDTH.
- Sub-module div20_step:
  - Purely combinational single restoring step.
  - Inputs: r, qw, dsr. Outputs: next r, next qw.
  - Instantiated once and reused each cycle.
- Top holds the FSM, step counter (5 bits, 0..20), working registers and output registers.

## Test plan
- 100/7: start at E0 → done after E20, quotient=14, remainder=2, div_by_zero=0, busy high exactly 20 cycles.
- 0xFFFFF/1 → quotient=0xFFFFF, remainder=0; then 3/10 issued in the DONE cycle → second done 20 cycles later, quotient=0, remainder=3.
- 5/0 → done after E1, quotient=0xFFFFF, remainder=5, div_by_zero=1, busy never high.
- start re-pulsed at E5 with 9/2 during 100/7 → ignored. Result stays 14/2; exactly one done.
- rst asserted mid-RUN (after E10) → all outputs 0 immediately, no done. A new 50/6 then returns 8/2.
- Random 1000 pairs, divisor≠0 → invariant holds; quotient/remainder stable between done pulses.
